gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Fetch-side dynamic branch predictor: a gshare pattern-history table (PHT) of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB). It looks up the fetch PC combinationally and steers next-PC. It registers prediction, hit and history snapshot into the IF/ID boundary for the decode stage. It trains from branches resolved in the execute stage.

## Interface
Parameters:
- PC_W, 5, instruction-word PC width; BTB depth = 2**PC_W
- GHR_W, 4, global history length; PHT depth = 2**GHR_W

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- pc_f  in  PC_W  PC currently being fetched
- if_id_write  in  1  IF/ID enable from hazard unit; 0 holds decode-side registers
- flush  in  1  squash IF/ID; decode-side registers load 0
- upd_valid  in  1  conditional branch (beq/bne) resolved in E this cycle
- upd_pc  in  PC_W  PC of resolving branch
- upd_idx  in  GHR_W  PHT index captured at that branch's fetch
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual taken target
- pred_taken_f  out  1  comb: redirect fetch to pred_target_f
- pred_target_f  out  PC_W  comb: BTB target for pc_f
- prediction_d  out  1  registered pred_taken_f
- hit_d  out  1  registered BTB hit
- ghr_d  out  GHR_W  registered GHR at fetch time
- idx_d  out  GHR_W  registered PHT index, piped to E as upd_idx

## Operation
- Index: idx_f = pc_f[GHR_W-1:0] XOR ghr.
- BTB entry: valid bit + PC_W target. Full-PC direct index, no tag. hit_f = valid[pc_f].
- pred_taken_f = hit_f AND pht[idx_f][1]. pred_target_f = btb_target[pc_f] regardless of hit.
- PHT counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - On upd_valid & upd_taken: pht[upd_idx] increments, saturating at 11.
  - On upd_valid & !upd_taken: pht[upd_idx] decrements, saturating at 00.
- BTB training: on upd_valid & upd_taken, valid[upd_pc]<=1 and target[upd_pc]<=upd_target. Not-taken never invalidates the entry.
- GHR is non-speculative: on upd_valid, ghr <= {ghr[GHR_W-2:0], upd_taken}. It never changes otherwise.
- Decode-side registers, in priority order:
  - flush=1: all load 0, including when if_id_write=0.
  - else if_id_write=1: load {pred_taken_f, hit_f, ghr, idx_f}.
  - else hold.
- Reset values: all PHT counters 01; all BTB valid 0, targets 0; ghr 0; prediction_d 0, hit_d 0, ghr_d 0, idx_d 0. Comb outputs after reset: pred_taken_f=0, pred_target_f=0.

## Timing
- Lookup is zero-latency combinational from pc_f and current table state.
- Update writes land at the clk edge ending the upd_valid cycle. They are visible to lookups the following cycle.
- Same-cycle update and lookup of the same PHT index or BTB entry: the lookup sees the pre-update value. There is no bypass.
- The GHR shift and the decode-register capture occur on the same edge. ghr_d therefore gets the old GHR.
- Reset asserted mid-operation clears everything immediately and asynchronously. An update pending on that edge is lost.
- Counter saturation: 11 + taken stays 11; 00 + not-taken stays 00. idx and PC arithmetic is pure bitwise; no wrap beyond width.

## Structure
- Shared package bp_pkg:
  - PC_W and GHR_W defaults
  - 2-bit counter type with SNT/WNT/WT/ST constants
  - PHT_RESET = WNT
- One sub-module, btb_table: valid+target array, comb read port, single write port, async active-low reset.
- PHT, GHR and IF/ID registers live in the top.

## Test plan
- Reset: hold reset=0, then release. Required: pred_taken_f=0 for every pc_f; ghr_d=0; all decode outputs 0.
- Training: branch at pc 6, target 20. Two upd_valid taken updates with the idx fetch reported.
  - After the first update: counter is WT, BTB valid, ghr=0001.
  - With pc_f=6 and ghr=0011: idx_f=0101. pred_taken_f reflects pht[5]. pred_target_f=20 regardless.
- Saturation: on a fixed idx, drive 4 taken updates then 1 not-taken. Required: counter sequence 01→10→11→11→11→10; prediction remains 1.
- Same-cycle hazard: upd_valid taken on pc 3 (first time) while pc_f=3. Required: hit_f=0 that cycle, hit_f=1 the next cycle.
- IF/ID control:
  - if_id_write=0 with changing pc_f: decode outputs held.
  - flush=1 together with if_id_write=0: decode outputs become 0.
- Async reset mid-run: assert reset between edges after training. Required: outputs and tables cleared before the next edge; the update in that cycle is discarded.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared widths, counter encoding and counter-step helper for the gshare predictor.
package bp_pkg;
  localparam int PC_W_DEF  = 5;
  localparam int GHR_W_DEF = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t PHT_RESET = WNT;

  // Saturating step of a 2-bit counter toward the resolved branch outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/btb_table.sv
// Direct-mapped, untagged branch target buffer: one valid bit and target per PC.
module btb_table
  import bp_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] i_rd_addr,
  output logic            o_rd_valid,
  output logic [PC_W-1:0] o_rd_target,
  input  logic            i_wr_en,
  input  logic [PC_W-1:0] i_wr_addr,
  input  logic [PC_W-1:0] i_wr_target
);
  localparam int DEPTH = 2**PC_W;

  logic [DEPTH-1:0] r_valid;
  logic [PC_W-1:0]  r_target [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_target[i] <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_addr]  <= 1'b1;
      r_target[i_wr_addr] <= i_wr_target;
    end
  end

  // Read port is purely combinational; a same-cycle write is not forwarded.
  assign o_rd_valid  = r_valid[i_rd_addr];
  assign o_rd_target = r_target[i_rd_addr];
endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: PHT of 2-bit counters indexed by pc XOR global history, plus BTB,
// with the prediction snapshot registered across the IF/ID boundary.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int GHR_W = GHR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc_f,
  input  logic             if_id_write,
  input  logic             flush,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [GHR_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  output logic             pred_taken_f,
  output logic [PC_W-1:0]  pred_target_f,
  output logic             prediction_d,
  output logic             hit_d,
  output logic [GHR_W-1:0] ghr_d,
  output logic [GHR_W-1:0] idx_d
);
  localparam int PHT_DEPTH = 2**GHR_W;

  ctr_t             r_pht [PHT_DEPTH];
  logic [GHR_W-1:0] r_ghr;
  logic             r_prediction_d;
  logic             r_hit_d;
  logic [GHR_W-1:0] r_ghr_d;
  logic [GHR_W-1:0] r_idx_d;

  logic [GHR_W-1:0] w_idx_f;
  logic [1:0]       w_ctr_f;
  logic             w_hit_f;
  logic [PC_W-1:0]  w_target_f;
  logic             w_pred_taken_f;
  logic             w_btb_wr;

  assign w_idx_f        = pc_f[GHR_W-1:0] ^ r_ghr;
  assign w_ctr_f        = r_pht[w_idx_f];
  assign w_pred_taken_f = w_hit_f & w_ctr_f[1];
  assign w_btb_wr       = upd_valid & upd_taken;

  btb_table #(
    .PC_W(PC_W)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .i_rd_addr  (pc_f),
    .o_rd_valid (w_hit_f),
    .o_rd_target(w_target_f),
    .i_wr_en    (w_btb_wr),
    .i_wr_addr  (upd_pc),
    .i_wr_target(upd_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= PHT_RESET;
    end else if (upd_valid) begin
      r_pht[upd_idx] <= ctr_next(r_pht[upd_idx], upd_taken);
    end
  end

  // History only advances on resolved branches, never on fetch-side guesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= {r_ghr[GHR_W-2:0], upd_taken};
    end
  end

  // Flush outranks the hazard-unit stall so a squashed slot never survives a hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prediction_d <= 1'b0;
      r_hit_d        <= 1'b0;
      r_ghr_d        <= '0;
      r_idx_d        <= '0;
    end else if (flush) begin
      r_prediction_d <= 1'b0;
      r_hit_d        <= 1'b0;
      r_ghr_d        <= '0;
      r_idx_d        <= '0;
    end else if (if_id_write) begin
      r_prediction_d <= w_pred_taken_f;
      r_hit_d        <= w_hit_f;
      r_ghr_d        <= r_ghr;
      r_idx_d        <= w_idx_f;
    end
  end

  assign pred_taken_f  = w_pred_taken_f;
  assign pred_target_f = w_target_f;
  assign prediction_d  = r_prediction_d;
  assign hit_d         = r_hit_d;
  assign ghr_d         = r_ghr_d;
  assign idx_d         = r_idx_d;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_gshare_branch_predictor;
  localparam int PC_W  = 5;
  localparam int GHR_W = 4;

  localparam int K_PRED_F = 0;
  localparam int K_TGT_F  = 1;
  localparam int K_PRED_D = 2;
  localparam int K_HIT_D  = 3;
  localparam int K_GHR_D  = 4;
  localparam int K_IDX_D  = 5;
  localparam int K_PHT    = 6;

  logic             clk;
  logic             reset;
  logic [PC_W-1:0]  pc_f;
  logic             if_id_write;
  logic             flush;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_idx;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             pred_taken_f;
  logic [PC_W-1:0]  pred_target_f;
  logic             prediction_d;
  logic             hit_d;
  logic [GHR_W-1:0] ghr_d;
  logic [GHR_W-1:0] idx_d;

  typedef struct {
    int    kind;
    int    aux;
    int    expVal;
    string name;
  } expItem_t;

  expItem_t expQ[$];
  int numChecks = 0;
  int numFails  = 0;

  gshare_branch_predictor #(
    .PC_W (PC_W),
    .GHR_W(GHR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_f         (pc_f),
    .if_id_write  (if_id_write),
    .flush        (flush),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .pred_taken_f (pred_taken_f),
    .pred_target_f(pred_target_f),
    .prediction_d (prediction_d),
    .hit_d        (hit_d),
    .ghr_d        (ghr_d),
    .idx_d        (idx_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] sampleDut(input int kind, input int aux);
    logic [31:0] v;
    logic [GHR_W-1:0] a;
    v = '0;
    a = aux[GHR_W-1:0];
    case (kind)
      K_PRED_F: v = 32'(pred_taken_f);
      K_TGT_F:  v = 32'(pred_target_f);
      K_PRED_D: v = 32'(prediction_d);
      K_HIT_D:  v = 32'(hit_d);
      K_GHR_D:  v = 32'(ghr_d);
      K_IDX_D:  v = 32'(idx_d);
      K_PHT:    v = 32'(dut.r_pht[a]);
      default:  v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  // Monitor: every expectation queued during a cycle is judged at that cycle's negedge.
  always @(negedge clk) begin
    expItem_t it;
    logic [31:0] act;
    while (expQ.size() > 0) begin
      it  = expQ.pop_front();
      act = sampleDut(it.kind, it.aux);
      numChecks++;
      if (act !== 32'(it.expVal)) begin
        numFails++;
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", it.name, $time, act, it.expVal);
      end
    end
  end

  task automatic applyStimulus(input logic [PC_W-1:0] pc, input logic wr, input logic fl,
                               input logic uv, input logic [PC_W-1:0] upc,
                               input logic [GHR_W-1:0] uidx, input logic ut,
                               input logic [PC_W-1:0] utgt);
    @(posedge clk);
    #1;
    pc_f        = pc;
    if_id_write = wr;
    flush       = fl;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_idx     = uidx;
    upd_taken   = ut;
    upd_target  = utgt;
  endtask

  task automatic checkOutput(input int kind, input int aux, input int expVal, input string name);
    expItem_t it;
    it = '{kind, aux, expVal, name};
    expQ.push_back(it);
  endtask

  task automatic idle(input logic [PC_W-1:0] pc);
    applyStimulus(pc, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] upc,
                        input logic [GHR_W-1:0] uidx, input logic ut, input logic [PC_W-1:0] utgt);
    applyStimulus(pc, 1'b1, 1'b0, 1'b1, upc, uidx, ut, utgt);
  endtask

  initial begin
    reset       = 1'b0;
    pc_f        = '0;
    if_id_write = 1'b1;
    flush       = 1'b0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_idx     = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;

    // Reset held: everything reads zero, counters sit at weakly-not-taken.
    idle(5'd6);
    checkOutput(K_PRED_F, 0, 0, "rst_pred_f");
    checkOutput(K_TGT_F,  0, 0, "rst_tgt_f");
    checkOutput(K_PRED_D, 0, 0, "rst_pred_d");
    checkOutput(K_HIT_D,  0, 0, "rst_hit_d");
    checkOutput(K_GHR_D,  0, 0, "rst_ghr_d");
    checkOutput(K_IDX_D,  0, 0, "rst_idx_d");
    checkOutput(K_PHT,    6, 1, "rst_pht6");
    idle(5'd6);
    reset = 1'b1;

    // Sweep every pc: nothing is predicted, idx_d is the previous pc's low bits.
    for (int p = 0; p < 32; p++) begin
      idle(5'(p));
      checkOutput(K_PRED_F, 0, 0, "sweep_pred_f");
      checkOutput(K_TGT_F,  0, 0, "sweep_tgt_f");
      checkOutput(K_IDX_D,  0, (p == 0) ? 6 : ((p - 1) & 15), "sweep_idx_d");
    end

    // Training the branch at pc 6 -> 20.
    idle(5'd6);
    checkOutput(K_PRED_F, 0, 0,  "trA_pred_f");
    checkOutput(K_TGT_F,  0, 0,  "trA_tgt_f");
    checkOutput(K_IDX_D,  0, 15, "trA_idx_d");
    update(5'd6, 5'd6, 4'd6, 1'b1, 5'd20);
    checkOutput(K_PRED_F, 0, 0, "trB_pred_f");
    checkOutput(K_TGT_F,  0, 0, "trB_tgt_nobypass");
    checkOutput(K_IDX_D,  0, 6, "trB_idx_d");
    idle(5'd6);
    checkOutput(K_PHT,    6, 2,  "trC_pht6_wt");
    checkOutput(K_TGT_F,  0, 20, "trC_tgt_f");
    checkOutput(K_PRED_F, 0, 0,  "trC_pred_f");
    checkOutput(K_GHR_D,  0, 0,  "trC_ghr_d_old");
    checkOutput(K_HIT_D,  0, 0,  "trC_hit_d");
    checkOutput(K_IDX_D,  0, 6,  "trC_idx_d");
    update(5'd6, 5'd6, 4'd7, 1'b1, 5'd20);
    checkOutput(K_GHR_D,  0, 1, "trD_ghr_d");
    checkOutput(K_IDX_D,  0, 7, "trD_idx_d");
    checkOutput(K_HIT_D,  0, 1, "trD_hit_d");
    checkOutput(K_PRED_D, 0, 0, "trD_pred_d");
    checkOutput(K_PRED_F, 0, 0, "trD_pred_f");
    idle(5'd6);
    checkOutput(K_PHT,    7, 2,  "trE_pht7_wt");
    checkOutput(K_PHT,    5, 1,  "trE_pht5_wnt");
    checkOutput(K_PRED_F, 0, 0,  "trE_pred_f");
    checkOutput(K_TGT_F,  0, 20, "trE_tgt_f");
    idle(5'd6);
    checkOutput(K_GHR_D, 0, 3, "trF_ghr_d");
    checkOutput(K_IDX_D, 0, 5, "trF_idx_d");
    checkOutput(K_HIT_D, 0, 1, "trF_hit_d");

    // Saturation on idx 5: 01 -> 10 -> 11 -> 11 -> 11 -> 10. Ghr ends at 1110.
    update(5'd6, 5'd6, 4'd5, 1'b1, 5'd20);
    checkOutput(K_PHT, 5, 1, "sat0");
    update(5'd6, 5'd6, 4'd5, 1'b1, 5'd20);
    checkOutput(K_PHT, 5, 2, "sat1");
    update(5'd6, 5'd6, 4'd5, 1'b1, 5'd20);
    checkOutput(K_PHT, 5, 3, "sat2");
    update(5'd6, 5'd11, 4'd5, 1'b1, 5'd9);
    checkOutput(K_PHT, 5, 3, "sat3");
    update(5'd6, 5'd6, 4'd5, 1'b0, 5'd20);
    checkOutput(K_PHT, 5, 3, "sat4");
    idle(5'd11);
    checkOutput(K_PHT,    5, 2, "sat5");
    checkOutput(K_PRED_F, 0, 1, "sat_pred_f");
    checkOutput(K_TGT_F,  0, 9, "sat_tgt_f");
    idle(5'd6);
    checkOutput(K_HIT_D,  0, 1,  "sat_hit_d");
    checkOutput(K_PRED_D, 0, 1,  "sat_pred_d");
    checkOutput(K_GHR_D,  0, 14, "sat_ghr_d");
    checkOutput(K_IDX_D,  0, 5,  "sat_idx_d");
    checkOutput(K_PRED_F, 0, 0,  "pc6_pred_f");
    checkOutput(K_TGT_F,  0, 20, "pc6_tgt_f");

    // Same-cycle write and lookup of BTB entry 3.
    update(5'd3, 5'd3, 4'd0, 1'b1, 5'd17);
    checkOutput(K_HIT_D,  0, 1, "nt_keeps_valid");
    checkOutput(K_IDX_D,  0, 8, "hz1_idx_d");
    checkOutput(K_PRED_F, 0, 0, "hz1_pred_f");
    checkOutput(K_TGT_F,  0, 0, "hz1_tgt_f");
    idle(5'd3);
    checkOutput(K_HIT_D,  0, 0,  "hz2_hit_old");
    checkOutput(K_TGT_F,  0, 17, "hz2_tgt_f");
    checkOutput(K_IDX_D,  0, 13, "hz2_idx_d");
    checkOutput(K_GHR_D,  0, 14, "hz2_ghr_d");
    checkOutput(K_PRED_F, 0, 0,  "hz2_pred_f");
    idle(5'd3);
    checkOutput(K_HIT_D, 0, 1,  "hz3_hit_new");
    checkOutput(K_GHR_D, 0, 13, "hz3_ghr_d");
    checkOutput(K_IDX_D, 0, 14, "hz3_idx_d");

    // IF/ID stall and flush.
    idle(5'd11);
    checkOutput(K_PRED_F, 0, 1, "if1_pred_f");
    checkOutput(K_TGT_F,  0, 9, "if1_tgt_f");
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput(K_PRED_D, 0, 1,  "hold1_pred_d");
    checkOutput(K_HIT_D,  0, 1,  "hold1_hit_d");
    checkOutput(K_GHR_D,  0, 13, "hold1_ghr_d");
    checkOutput(K_IDX_D,  0, 6,  "hold1_idx_d");
    checkOutput(K_PRED_F, 0, 0,  "hold1_pred_f");
    applyStimulus(5'd5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput(K_PRED_D, 0, 1, "hold2_pred_d");
    checkOutput(K_IDX_D,  0, 6, "hold2_idx_d");
    applyStimulus(5'd11, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    checkOutput(K_PRED_D, 0, 1, "fl0_pred_d");
    checkOutput(K_HIT_D,  0, 1, "fl0_hit_d");
    applyStimulus(5'd11, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput(K_PRED_D, 0, 0, "fl1_pred_d");
    checkOutput(K_HIT_D,  0, 0, "fl1_hit_d");
    checkOutput(K_GHR_D,  0, 0, "fl1_ghr_d");
    checkOutput(K_IDX_D,  0, 0, "fl1_idx_d");
    idle(5'd11);
    checkOutput(K_PRED_D, 0, 0, "fl2_pred_d");
    idle(5'd11);
    checkOutput(K_PRED_D, 0, 1,  "rel_pred_d");
    checkOutput(K_IDX_D,  0, 6,  "rel_idx_d");
    checkOutput(K_GHR_D,  0, 13, "rel_ghr_d");

    // Asynchronous reset between edges with an update pending.
    update(5'd11, 5'd20, 4'd6, 1'b1, 5'd5);
    #2;
    reset = 1'b0;
    checkOutput(K_PRED_D, 0, 0, "arst_pred_d");
    checkOutput(K_HIT_D,  0, 0, "arst_hit_d");
    checkOutput(K_GHR_D,  0, 0, "arst_ghr_d");
    checkOutput(K_IDX_D,  0, 0, "arst_idx_d");
    checkOutput(K_PRED_F, 0, 0, "arst_pred_f");
    checkOutput(K_TGT_F,  0, 0, "arst_tgt_f");
    checkOutput(K_PHT,    6, 1, "arst_pht6");
    idle(5'd20);
    reset = 1'b1;
    checkOutput(K_TGT_F,  0, 0, "lost_btb20");
    checkOutput(K_PRED_F, 0, 0, "lost_pred_f");
    checkOutput(K_PHT,    6, 1, "lost_pht6");
    checkOutput(K_GHR_D,  0, 0, "lost_ghr_d");
    idle(5'd20);
    checkOutput(K_GHR_D, 0, 0, "lost_ghr");
    checkOutput(K_IDX_D, 0, 4, "post_idx_d");
    checkOutput(K_HIT_D, 0, 0, "post_hit_d");

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end
endmodule
